// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI write-path constants and the FSM state encoding used by the AW/W/B engines.
package axi_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    typedef enum logic [1:0] {IDLE, VALID, BURST, RESP} state_e;
endpackage

// File: rtl/axi_sync_fifo.sv
// axi_sync_fifo: first-word-fall-through synchronous FIFO, power-of-two depth, async active-high reset.
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, rd_q;
    assign empty_o = wr_q == rd_q;
    assign dout_o  = mem_q[rd_q[PW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q[PW-1:0]] <= din_i;
                wr_q <= wr_q + (PW+1)'(1);
            end
            if (pop_i) rd_q <= rd_q + (PW+1)'(1);
        end
    end
endmodule

// File: rtl/axi_wr_protocol_fsm.sv
// axi_wr_protocol_fsm: AXI write-path engine turning stimulus requests into protocol-legal AW/W/B traffic
// with up to MAX_OUTS bursts in flight and in-order B responses.
module axi_wr_protocol_fsm
    import axi_pkg::*;
#(
    parameter int IDW      = 4,
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int MAX_OUTS = 4
) (
    input  logic                        axi_aclk,
    input  logic                        rst,
    input  logic [IDW-1:0]              awid_in,
    input  logic [AW-1:0]               awaddr_in,
    input  logic [7:0]                  awlen_in,
    input  logic [2:0]                  awsize_in,
    input  logic [1:0]                  awburst_in,
    input  logic                        awvalid_in,
    output logic                        aw_accept,
    input  logic [DW-1:0]               wdata_in,
    input  logic [DW/8-1:0]             wstrb_in,
    input  logic                        wvalid_in,
    output logic                        w_accept,
    input  logic                        awready_in,
    input  logic                        wready_in,
    input  logic                        bready_in,
    output logic [IDW-1:0]              axi_awid,
    output logic [AW-1:0]               axi_awaddr,
    output logic [7:0]                  axi_awlen,
    output logic [2:0]                  axi_awsize,
    output logic [1:0]                  axi_awburst,
    output logic                        axi_awvalid,
    output logic [DW-1:0]               axi_wdata,
    output logic [DW/8-1:0]             axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    output logic [IDW-1:0]              axi_bid,
    output logic [1:0]                  axi_bresp,
    output logic                        axi_bvalid,
    output logic [$clog2(MAX_OUTS):0]   outs_cnt
);
    localparam int CW = $clog2(MAX_OUTS) + 1;
    state_e           aw_state_q, w_state_q, b_state_q;
    logic [IDW-1:0]   awid_q, wid_q, bid_q;
    logic [AW-1:0]    awaddr_q;
    logic [7:0]       awlen_q, beat_cnt_q;
    logic [2:0]       awsize_q;
    logic [1:0]       awburst_q;
    logic [DW-1:0]    wdata_q;
    logic [DW/8-1:0]  wstrb_q;
    logic             wlast_q;
    logic [CW-1:0]    outs_cnt_q;
    logic [CW:0]      outs_d;
    logic             aw_hs, w_hs, b_hs, aw_load, w_load, w_last_ld, b_load, bf_empty, rf_empty;
    logic [IDW+7:0]   bf_dout;
    logic [IDW-1:0]   rf_dout;
    assign axi_awvalid = aw_state_q == VALID;
    assign axi_wvalid  = w_state_q == BURST;
    assign axi_bvalid  = b_state_q == RESP;
    assign aw_hs = axi_awvalid & awready_in;
    assign w_hs  = axi_wvalid & wready_in;
    assign b_hs  = axi_bvalid & bready_in;
    assign outs_d    = {1'b0, outs_cnt_q} + (CW+1)'(aw_hs) - (CW+1)'(b_hs);
    assign aw_load   = !rst & (!axi_awvalid | aw_hs) & awvalid_in & (outs_d < (CW+1)'(MAX_OUTS));
    assign w_load    = !rst & (!axi_wvalid | w_hs) & wvalid_in & !bf_empty;
    assign w_last_ld = w_load & (beat_cnt_q == bf_dout[7:0]);
    assign b_load    = !rst & (!axi_bvalid | b_hs) & !rf_empty;
    assign aw_accept = aw_load;
    assign w_accept  = w_load;
    assign {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst} = {awid_q, awaddr_q, awlen_q, awsize_q, awburst_q};
    assign {axi_wdata, axi_wstrb, axi_wlast} = {wdata_q, wstrb_q, wlast_q};
    assign axi_bid   = bid_q;
    assign axi_bresp = RESP_OKAY;
    assign outs_cnt  = outs_cnt_q;
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) outs_cnt_q <= '0;
        else outs_cnt_q <= outs_d[CW-1:0];
    end
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            aw_state_q <= IDLE;
            {awid_q, awaddr_q, awlen_q, awsize_q, awburst_q} <= '0;
        end else if (aw_load) begin
            aw_state_q <= VALID;
            {awid_q, awaddr_q, awlen_q, awsize_q, awburst_q} <= {awid_in, awaddr_in, awlen_in, awsize_in, awburst_in};
        end else if (aw_hs) begin
            aw_state_q <= IDLE;
        end
    end
    // beat_cnt counts beats loaded for the head burst, which is popped as its last beat loads,
    // so the next burst's first beat sees the correct head in the same cycle.
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            w_state_q  <= IDLE;
            {wdata_q, wstrb_q, wlast_q, wid_q} <= '0;
            beat_cnt_q <= '0;
        end else if (w_load) begin
            w_state_q  <= BURST;
            {wdata_q, wstrb_q, wlast_q, wid_q} <= {wdata_in, wstrb_in, w_last_ld, bf_dout[IDW+7:8]};
            beat_cnt_q <= w_last_ld ? 8'd0 : beat_cnt_q + 8'd1;
        end else if (w_hs) begin
            w_state_q <= IDLE;
            wlast_q   <= 1'b0;
        end
    end
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            b_state_q <= IDLE;
            bid_q     <= '0;
        end else if (b_load) begin
            b_state_q <= RESP;
            bid_q     <= rf_dout;
        end else if (b_hs) begin
            b_state_q <= IDLE;
        end
    end
    axi_sync_fifo #(.WIDTH(IDW + 8), .DEPTH(MAX_OUTS)) u_burst_fifo (
        .clk(axi_aclk), .rst(rst), .push_i(aw_hs), .pop_i(w_last_ld),
        .din_i({awid_q, awlen_q}), .dout_o(bf_dout), .empty_o(bf_empty)
    );
    axi_sync_fifo #(.WIDTH(IDW), .DEPTH(MAX_OUTS)) u_resp_fifo (
        .clk(axi_aclk), .rst(rst), .push_i(w_hs & wlast_q), .pop_i(b_load),
        .din_i(wid_q), .dout_o(rf_dout), .empty_o(rf_empty)
    );
endmodule
